modulation_segment_1_with_control: RTL and testbench

Combines ten 32-bit segment words into one 32-bit modulated word, `output_bit`, through a 3-stage pipelined adder tree. All sums wrap modulo 2^32. A start/valid/busy control counter wraps the datapath. It is the transmit-side counterpart of the segment-1 demodulation stage: the demodulator splits a word into ten segments, and this block recombines ten segments into a word.

---
 rtl/modulation_pkg.sv | 14 +
 rtl/modulation_segment_1.sv | 48 ++++
 rtl/modulation_segment_1_with_control.sv | 53 +++++
 tb/tb_modulation_segment_1_with_control.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/modulation_pkg.sv
// rtl/modulation_pkg.sv - constants and types shared by the segment modulation and demodulation stages
package modulation_pkg;

  localparam int SEG_COUNT   = 10;
  localparam int SEG_WIDTH   = 32;
  localparam int MOD_LATENCY = 3;
  localparam int CNT_WIDTH   = 4;

  typedef logic [SEG_WIDTH-1:0] seg_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_DONE = cnt_t'(MOD_LATENCY);

endpackage

// File: rtl/modulation_segment_1.sv
// rtl/modulation_segment_1.sv - free-running 3-stage adder tree summing ten segments mod 2^32
module modulation_segment_1
  import modulation_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  seg_t segment_0,
  input  seg_t segment_1,
  input  seg_t segment_2,
  input  seg_t segment_3,
  input  seg_t segment_4,
  input  seg_t segment_5,
  input  seg_t segment_6,
  input  seg_t segment_7,
  input  seg_t segment_8,
  input  seg_t segment_9,
  output seg_t output_bit
);

  seg_t p0, p1, p2, p3, p4;
  seg_t q0, q1, q2;

  // Carries out of bit 31 fall off naturally because every register is seg_t wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      p4         <= '0;
      q0         <= '0;
      q1         <= '0;
      q2         <= '0;
      output_bit <= '0;
    end else begin
      p0         <= segment_0 + segment_1;
      p1         <= segment_2 + segment_3;
      p2         <= segment_4 + segment_5;
      p3         <= segment_6 + segment_7;
      p4         <= segment_8 + segment_9;
      q0         <= p0 + p1;
      q1         <= p2 + p3;
      q2         <= p4;
      output_bit <= q0 + q1 + q2;
    end
  end

endmodule

// File: rtl/modulation_segment_1_with_control.sv
// rtl/modulation_segment_1_with_control.sv - segment modulator with start/valid/busy control counter
module modulation_segment_1_with_control
  import modulation_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  seg_t segment_0,
  input  seg_t segment_1,
  input  seg_t segment_2,
  input  seg_t segment_3,
  input  seg_t segment_4,
  input  seg_t segment_5,
  input  seg_t segment_6,
  input  seg_t segment_7,
  input  seg_t segment_8,
  input  seg_t segment_9,
  input  logic start,
  output seg_t output_bit,
  output logic valid,
  output logic busy
);

  cnt_t counter;

  modulation_segment_1 u_datapath (
    .clk        (clk),
    .reset      (reset),
    .segment_0  (segment_0),
    .segment_1  (segment_1),
    .segment_2  (segment_2),
    .segment_3  (segment_3),
    .segment_4  (segment_4),
    .segment_5  (segment_5),
    .segment_6  (segment_6),
    .segment_7  (segment_7),
    .segment_8  (segment_8),
    .segment_9  (segment_9),
    .output_bit (output_bit)
  );

  // Counts consecutive start-high edges and saturates at the pipeline depth.
  always_ff @(posedge clk) begin
    if (reset || !start) begin
      counter <= '0;
    end else if (counter < CNT_DONE) begin
      counter <= counter + cnt_t'(1);
    end
  end

  assign valid = (counter == CNT_DONE);
  assign busy  = ~valid;

endmodule

// File: tb/tb_modulation_segment_1_with_control.sv
// tb/tb_modulation_segment_1_with_control.sv - self-checking bench for modulation_segment_1_with_control
module tb_modulation_segment_1_with_control;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] seg [10];
  logic [31:0] output_bit;
  logic        valid;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference: sum history shifted one slot per edge, plus a run length of start-high edges.
  logic [31:0] hist [3];
  int          run_len;
  logic        check_en = 1'b0;

  modulation_segment_1_with_control dut (
    .clk        (clk),
    .reset      (reset),
    .segment_0  (seg[0]),
    .segment_1  (seg[1]),
    .segment_2  (seg[2]),
    .segment_3  (seg[3]),
    .segment_4  (seg[4]),
    .segment_5  (seg[5]),
    .segment_6  (seg[6]),
    .segment_7  (seg[7]),
    .segment_8  (seg[8]),
    .segment_9  (seg[9]),
    .start      (start),
    .output_bit (output_bit),
    .valid      (valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seg_sum();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 10; i++) s = s + seg[i];
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist[0] = 32'd0;
      hist[1] = 32'd0;
      hist[2] = 32'd0;
      run_len = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = seg_sum();
      run_len = start ? run_len + 1 : 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_output_bit", output_bit, hist[2]);
      check("model_valid", {31'd0, valid}, {31'd0, run_len >= 3});
      check("model_busy", {31'd0, busy}, {31'd0, run_len < 3});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 10; i++) seg[i] = 32'(i + 1);
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 10; i++) seg[i] = v;
  endtask

  task automatic expect_out(input string name, input logic [31:0] ob, input logic v);
    check({name, "_output_bit"}, output_bit, ob);
    check({name, "_valid"}, {31'd0, valid}, {31'd0, v});
    check({name, "_busy"}, {31'd0, busy}, {31'd0, ~v});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) seg[i] = $urandom;

    tick();
    check_en = 1'b1;
    expect_out("reset_cycle1", 32'd0, 1'b0);
    tick();
    expect_out("reset_cycle2", 32'd0, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("reset_release", 32'd0, 1'b0);

    // Basic sum 1..10 = 0x37
    start = 1'b0;
    set_ramp();
    tick();
    start = 1'b1;
    tick();
    check("basic_edge1_valid", {31'd0, valid}, 32'd0);
    tick();
    check("basic_edge2_valid", {31'd0, valid}, 32'd0);
    tick();
    expect_out("basic_edge3", 32'h0000_0037, 1'b1);

    // Streaming: new segments show up exactly 3 edges later
    set_all(32'h0000_0001);
    tick();
    expect_out("stream_edge1", 32'h0000_0037, 1'b1);
    tick();
    expect_out("stream_edge2", 32'h0000_0037, 1'b1);
    tick();
    expect_out("stream_edge3", 32'h0000_000A, 1'b1);

    // Wrap-around cases
    start = 1'b0;
    set_all(32'hFFFF_FFFF);
    tick();
    check("wrap_abort_valid", {31'd0, valid}, 32'd0);
    start = 1'b1;
    repeat (3) tick();
    expect_out("wrap_all_ones", 32'hFFFF_FFF6, 1'b1);

    start = 1'b0;
    set_all(32'd0);
    seg[0] = 32'h8000_0000;
    seg[1] = 32'h8000_0000;
    tick();
    start = 1'b1;
    repeat (3) tick();
    expect_out("wrap_msb_pair", 32'h0000_0000, 1'b1);

    // Abort: 2 high, 1 low, 3 high
    start = 1'b0;
    set_ramp();
    tick();
    start = 1'b1;
    tick();
    check("abort_a1_valid", {31'd0, valid}, 32'd0);
    tick();
    check("abort_a2_valid", {31'd0, valid}, 32'd0);
    start = 1'b0;
    tick();
    check("abort_low_valid", {31'd0, valid}, 32'd0);
    start = 1'b1;
    tick();
    check("abort_b1_valid", {31'd0, valid}, 32'd0);
    tick();
    check("abort_b2_valid", {31'd0, valid}, 32'd0);
    tick();
    expect_out("abort_b3", 32'h0000_0037, 1'b1);
    repeat (4) tick();
    expect_out("abort_hold", 32'h0000_0037, 1'b1);

    // Mid-operation reset with start still high
    reset = 1'b1;
    tick();
    expect_out("midrst_pulse", 32'd0, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("midrst_edge1", 32'd0, 1'b0);
    tick();
    expect_out("midrst_edge2", 32'd0, 1'b0);
    tick();
    expect_out("midrst_edge3", 32'h0000_0037, 1'b1);

    repeat (2) tick();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
